// File: rtl/io_stream_fifo.sv
// Streaming FIFO with valid/ready handshakes, synchronous flush and a sticky overflow flag.
// OVERWRITE selects between back-pressure on full and discarding the oldest entry.
module io_stream_fifo #(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         io_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         io_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             drop_oldest;
  logic             refused;

  // Assertion takes effect at once; release is retimed through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign full        = (count == FULL_COUNT);
  assign in_ready    = (OVERWRITE != 0) ? 1'b1 : !full;
  assign out_valid   = (count != '0);
  assign io_out      = out_valid ? mem[rd_ptr] : '0;
  assign do_pop      = out_valid && out_ready;
  assign do_push     = in_valid && in_ready;
  // Only reachable with OVERWRITE=1, since in_ready is low on full otherwise.
  assign drop_oldest = do_push && full && !do_pop;
  assign refused     = in_valid && !in_ready && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= io_in;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)               wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || drop_oldest) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop && !full)  count <= count + 1'b1;
      else if (do_pop && !do_push)      count <= count - 1'b1;
      if (drop_oldest || refused) overflow <= 1'b1;
    end
  end

endmodule
